// File: rtl/pipeline_muldiv_pkg.sv
// rtl/pipeline_muldiv_pkg.sv - op encodings, FSM states and op-class helpers for pipeline_muldiv
package pipeline_muldiv_pkg;

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MTHI  = 4'b0100;
  localparam logic [3:0] OP_MTLO  = 4'b0101;
  localparam logic [3:0] OP_MADD  = 4'b0110;
  localparam logic [3:0] OP_MADDU = 4'b0111;
  localparam logic [3:0] OP_MSUB  = 4'b1000;
  localparam logic [3:0] OP_MSUBU = 4'b1001;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_macc(input logic [3:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/pipeline_muldiv_step.sv
// rtl/pipeline_muldiv_step.sv - one shift-add multiply or restoring shift-subtract divide iteration
module pipeline_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] part_hi,
  input  logic [WIDTH-1:0] part_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo,
  output logic             q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Multiply: {hi,lo} holds partial product over remaining multiplier bits, shifted right.
  // Divide: {hi,lo} holds remainder over remaining dividend bits, shifted left; the
  // caller merges q_bit into the vacated LSB of next_lo.
  always_comb begin
    sum     = {1'b0, part_hi} + (part_lo[0] ? {1'b0, operand} : '0);
    shifted = {part_hi, part_lo[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    next_hi = sum[WIDTH:1];
    next_lo = {sum[0], part_lo[WIDTH-1:1]};
    q_bit   = 1'b0;
    if (is_div) begin
      next_lo = {part_lo[WIDTH-2:0], 1'b0};
      if (!diff[WIDTH]) begin
        next_hi = diff[WIDTH-1:0];
        q_bit   = 1'b1;
      end else begin
        next_hi = shifted[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/pipeline_muldiv.sv
// rtl/pipeline_muldiv.sv - iterative MULT/DIV unit with HI/LO; PIPELINE_MULDIV_MACC_EN adds MADD/MSUB
module pipeline_muldiv
  import pipeline_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_data_A,
  input  logic [WIDTH-1:0] i_data_B,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               neg_res, neg_rem;
  logic               busy_q, done_q;

  logic               macc_ok, accept_run, sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               step_q;
  logic [2*WIDTH-1:0] prod, prod_s, fix_hilo;

`ifdef PIPELINE_MULDIV_MACC_EN
  assign macc_ok = is_macc(i_op);
`else
  assign macc_ok = 1'b0;
`endif

  assign accept_run = is_mul(i_op) || is_div(i_op) || macc_ok;
  assign sgn        = is_signed(i_op);
  assign mag_a      = (sgn && i_data_A[WIDTH-1]) ? -i_data_A : i_data_A;
  assign mag_b      = (sgn && i_data_B[WIDTH-1]) ? -i_data_B : i_data_B;

  pipeline_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div(op_q)),
    .part_hi (acc_hi),
    .part_lo (acc_lo),
    .operand (opnd),
    .next_hi (step_hi),
    .next_lo (step_lo),
    .q_bit   (step_q)
  );

  // Sign correction, optional accumulate and HI/LO packing applied at the FIX edge
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_s   = neg_res ? -prod : prod;
    fix_hilo = prod_s;
    if (is_div(op_q)) begin
      fix_hilo = {(neg_rem ? -acc_hi : acc_hi), (neg_res ? -acc_lo : acc_lo)};
    end
`ifdef PIPELINE_MULDIV_MACC_EN
    else if (is_macc(op_q)) begin
      fix_hilo = is_sub(op_q) ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
    end
`endif
  end

  // Control FSM with registered busy/done and architectural HI/LO
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      op_q    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start && !i_flush) begin
            if (accept_run) begin
              state   <= ST_RUN;
              cnt     <= CNT_INIT;
              busy_q  <= 1'b1;
              op_q    <= i_op;
              acc_hi  <= '0;
              neg_res <= sgn && (i_data_A[WIDTH-1] ^ i_data_B[WIDTH-1]);
              neg_rem <= sgn && i_data_A[WIDTH-1];
              if (is_div(i_op)) begin
                acc_lo <= mag_a;
                opnd   <= mag_b;
              end else begin
                acc_lo <= mag_b;
                opnd   <= mag_a;
              end
            end else if (i_op == OP_MTHI) begin
              hi_q <= i_data_A;
            end else if (i_op == OP_MTLO) begin
              lo_q <= i_data_A;
            end
          end
        end
        ST_RUN: begin
          if (i_flush) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo | {{(WIDTH-1){1'b0}}, step_q};
            cnt    <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          if (!i_flush) begin
            {hi_q, lo_q} <= fix_hilo;
            done_q       <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_pipeline_muldiv.sv
// tb/tb_pipeline_muldiv.sv - directed vector bench for pipeline_muldiv
module tb_pipeline_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] data_a, data_b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  pipeline_muldiv #(.WIDTH(32)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_op     (op),
    .i_data_A (data_a),
    .i_data_B (data_b),
    .i_flush  (flush),
    .o_busy   (busy),
    .o_done   (done),
    .o_hi     (hi),
    .o_lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one op (called #1 after an edge) and waits for o_done; optionally
  // pulses a competing i_start with other operands at cycle inj_cyc.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj_cyc, output int lat, output int busy_cyc);
    start = 1'b1; op = o; data_a = a; data_b = b;
    lat = 0; busy_cyc = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (inj_cyc != 0 && c == inj_cyc) begin
        start = 1'b1; op = 4'b0001; data_a = 32'h0000_0005; data_b = 32'h0000_0009;
      end
      if (busy) busy_cyc++;
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] a);
    start = 1'b1; op = o; data_a = a; data_b = '0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int lat, bc, ndone;
    logic [31:0] save_hi, save_lo;

    vecs[0] = '{4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{4'b0000, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{4'b0010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{4'b0011, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    vecs[4] = '{4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{4'b0011, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[6] = '{4'b0000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7] = '{4'b0010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8] = '{4'b0001, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

    rst_n = 1'b0; start = 1'b0; op = '0; data_a = '0; data_b = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", {32'h0, hi}, 64'h0);
    chk("reset_lo", {32'h0, lo}, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back vectors: each new i_start lands in the o_done cycle of the previous op
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, lat, bc);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd34);
      chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'd33);
      chk($sformatf("v%0d_hi", i), {32'h0, hi}, {32'h0, vecs[i].exp_hi});
      chk($sformatf("v%0d_lo", i), {32'h0, lo}, {32'h0, vecs[i].exp_lo});
    end
    @(posedge clk); #1;
    chk("done_one_cycle", {63'h0, done}, 64'h0);

    // Flush in cycle 10 of a MULT: no done, HI/LO retained
    save_hi = hi; save_lo = lo;
    start = 1'b1; op = 4'b0000; data_a = 32'h0000_0003; data_b = 32'h0000_0004;
    ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) ndone++;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'h0, busy}, 64'h0);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("flush_no_done", 64'(ndone), 64'd0);
    chk("flush_hi", {32'h0, hi}, {32'h0, save_hi});
    chk("flush_lo", {32'h0, lo}, {32'h0, save_lo});

    // Competing i_start at cycle 5 of a DIVU is ignored
    run_op(4'b0011, 32'h0000_0064, 32'h0000_0007, 5, lat, bc);
    chk("ign_latency", 64'(lat), 64'd34);
    chk("ign_hi", {32'h0, hi}, 64'h2);
    chk("ign_lo", {32'h0, lo}, 64'hE);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_no_restart", {63'h0, busy}, 64'h0);

    // MTHI/MTLO are single-edge writes with no busy
    mt(4'b0101, 32'h0000_0000);
    chk("mtlo_lo", {32'h0, lo}, 64'h0);
    mt(4'b0100, 32'hA5A5_A5A5);
    chk("mthi_hi", {32'h0, hi}, 64'hA5A5_A5A5);
    chk("mthi_busy", {63'h0, busy}, 64'h0);
    @(posedge clk); #1;
    chk("mthi_no_done", {63'h0, done}, 64'h0);

    // Unknown op is ignored
    mt(4'b1111, 32'h1111_1111);
    repeat (2) @(posedge clk);
    #1;
    chk("unk_busy", {63'h0, busy}, 64'h0);
    chk("unk_hilo", {hi, lo}, {32'hA5A5_A5A5, 32'h0});

`ifdef PIPELINE_MULDIV_MACC_EN
    run_op(4'b0111, 32'h0000_0002, 32'h0000_0003, 0, lat, bc);
    chk("maddu_latency", 64'(lat), 64'd34);
    chk("maddu_hilo", {hi, lo}, {32'hA5A5_A5A5, 32'h0000_0006});
    run_op(4'b1000, 32'h0000_0002, 32'hFFFF_FFFD, 0, lat, bc);
    chk("msub_hilo", {hi, lo}, {32'hA5A5_A5A5, 32'h0000_000C});
`else
    start = 1'b1; op = 4'b0111; data_a = 32'h2; data_b = 32'h3;
    ndone = 0;
    bc = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) bc++;
      if (done) ndone++;
    end
    chk("maddu_off_busy", 64'(bc), 64'd0);
    chk("maddu_off_done", 64'(ndone), 64'd0);
    chk("maddu_off_hilo", {hi, lo}, {32'hA5A5_A5A5, 32'h0});
`endif

    // Reset in the middle of RUN
    start = 1'b1; op = 4'b0000; data_a = 32'h0000_0003; data_b = 32'h0000_0004;
    repeat (10) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("pre_rst_busy", {63'h0, busy}, 64'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_hi", {32'h0, hi}, 64'h0);
    chk("rst_lo", {32'h0, lo}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_muldiv.md
# pipeline_muldiv

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It sits beside the pipeline ALU in the EX stage and executes MULT/MULTU/DIV/DIVU, and optionally multiply-accumulate, over WIDTH+1 cycles. It stalls the pipeline through a busy flag while it runs. HI/LO are exposed continuously so MFHI/MFLO are plain reads.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; must be ≥ 4 and even
- CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived; do not override)

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_start  in  1  issue request; accepted only while the state is IDLE
- i_op  in  4  operation: 0000 MULT, 0001 MULTU, 0010 DIV, 0011 DIVU, 0100 MTHI, 0101 MTLO, 0110 MADD, 0111 MADDU, 1000 MSUB, 1001 MSUBU; other codes are no-ops
- i_data_A  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
- i_data_B  in  WIDTH  rt operand (multiplier / divisor)
- i_flush  in  1  cancels any in-flight operation
- o_busy  out  1  high while an operation is in flight; the pipeline must stall EX
- o_done  out  1  one-cycle pulse in the cycle after HI/LO are written
- o_hi  out  WIDTH  HI register
- o_lo  out  WIDTH  LO register

## Operation
- States:
  - IDLE: waiting for i_start
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, for WIDTH cycles
  - FIX: one cycle for sign correction, the optional accumulate, and the HI/LO write
- IDLE transitions:
  - i_start with a MULT/DIV-class op: operands are latched and the state moves to RUN with the counter set to WIDTH.
  - MTHI/MTLO: the register is written at the acceptance edge and the state stays IDLE; no busy, no done.
  - Unknown op: ignored.
- RUN decrements the counter each cycle and moves to FIX when the counter reaches 0. FIX always returns to IDLE.
- Signed operations compute on magnitudes.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ; the remainder takes the dividend's sign.
- Result placement: multiply writes {HI,LO} = 2·WIDTH-bit product. Divide writes LO = quotient, HI = remainder.
- Divide by zero gives HI = dividend and LO = all ones (unsigned), or the sign-corrected equivalent for DIV. No exception is raised.
- DIV of most-negative by −1 gives LO = most-negative (wrap) and HI = 0.
- i_start while busy is ignored. i_start in the same cycle as o_done is accepted (the state is IDLE).
- i_flush in RUN or FIX returns the state to IDLE next edge with HI/LO unchanged; o_done is not pulsed. i_flush has priority over i_start.
- Reset, including mid-operation: state IDLE, o_hi = 0, o_lo = 0, o_busy = 0, o_done = 0, counter = 0.

## Timing
- Acceptance edge E0. RUN occupies edges E1..EWIDTH. FIX writes HI/LO at edge EWIDTH+1.
- o_busy is high from the cycle after E0 up to and including the cycle ending at EWIDTH+1. It is registered and derived from state ≠ IDLE.
- o_done is high for exactly the one cycle after EWIDTH+1. Total latency is WIDTH+2 cycles from i_start to o_done (34 for WIDTH=32).
- MTHI/MTLO results are visible on o_hi/o_lo in the cycle after E0.
- There is no combinational path from i_op, i_data_A or i_data_B to any output.

## Configuration
- PIPELINE_MULDIV_MACC_EN:
  - Defined: MADD/MADDU/MSUB/MSUBU are supported. In FIX, {HI,LO} ± product is computed mod 2^(2·WIDTH) and written. Latency is unchanged.
  - Undefined: op codes 0110–1001 are treated as unknown and ignored; the accumulate adder is absent.

## Structure
- Package pipeline_muldiv_pkg holds the op encodings, the state enum (IDLE/RUN/FIX), and helper constants for operation classes (is_mul, is_div, is_signed).
- One sub-module, pipeline_muldiv_step: a combinational single iteration. It takes the partial remainder/product, operand and mode, and returns the next partial value plus a quotient bit. It is instantiated once in the top-level FSM.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> o_done 34 cycles after i_start; HI=0xFFFFFFFE, LO=0x00000001; o_busy high for 33 cycles.
- MULT −3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV −7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x00001234. DIV 0x80000000 / −1 -> LO=0x80000000, HI=0.
- Start MULT, assert i_flush at cycle 10 -> IDLE next edge, no o_done, HI/LO keep prior values. Second i_start at cycle 5 of a DIV is ignored.
- MTHI 0xA5A5A5A5 then MADDU 2×3 (macro defined) -> HI=0xA5A5A5A5, LO=0x00000006. With the macro undefined -> op ignored, o_busy stays 0.
- Assert i_rst_n low mid-RUN -> next edge o_hi=o_lo=0, o_busy=0, o_done=0.
